// File: rtl/music_seq_memory.sv
// Writable note-sequence memory with a tempo-divided playback engine.
// Notes are appended in IDLE; playback presents one registered note word per step.
module music_seq_memory #(
  parameter int DATA_WIDTH    = 10,
  parameter int DEPTH         = 256,
  parameter int ADDR_W        = 9,
  parameter int TICK_W        = 27,
  parameter int BASE_INTERVAL = 12500000,
  parameter int DUR_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  loop_en,
  input  logic [TICK_W-1:0]     tick_div,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  output_ready,
  output logic [ADDR_W-1:0]     play_pos,
  output logic [ADDR_W-1:0]     count,
  output logic                  full,
  output logic                  done,
  output logic [DUR_W-1:0]      duration
);

  // state   | meaning
  // S_IDLE  | accepting writes/clears, waiting for start
  // S_PLAY  | stepping through stored notes
  // S_PAUSE | position and step counter frozen, outputs blanked
  // S_DONE  | single-cycle end-of-playback marker

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW     = ADDR_W + TICK_W;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     count_q, count_d;
  logic [TICK_W-1:0]     div_q, div_d;
  logic [TICK_W-1:0]     step_q, step_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  ready_q, ready_d;
  logic [ADDR_W-1:0]     pos_q, pos_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic            mem_we;
  logic            full_w;
  logic            step_end;
  logic            last_step;
  logic            ending;
  logic [PW-1:0]   prod_w;
  logic [PW-1:0]   quot_w;

  assign full_w    = (count_q == ADDR_W'(DEPTH));
  assign step_end  = (step_q == div_q);
  assign last_step = (ptr_q == (count_q - ADDR_W'(1)));
  assign ending    = step_end && last_step && !loop_en;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    step_d  = step_q;
    ptr_d   = ptr_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        step_d = TICK_W'(1);
        ptr_d  = '0;
        if (clear) begin
          count_d = '0;
        end else if (write_en && !full_w) begin
          mem_we  = 1'b1;
          count_d = count_q + ADDR_W'(1);
        end
        if (!stop && start && (count_q != '0)) begin
          state_d = S_PLAY;
          div_d   = (tick_div == '0) ? TICK_W'(1) : tick_div;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          // The cycle in which pause is sampled still counts toward the step.
          if (step_end) begin
            step_d = TICK_W'(1);
            ptr_d  = last_step ? '0 : (ptr_q + ADDR_W'(1));
          end else begin
            step_d = step_q + TICK_W'(1);
          end
          if (ending)     state_d = S_DONE;
          else if (pause) state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (stop)        state_d = S_IDLE;
        else if (!pause) state_d = S_PLAY;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_out_d = '0;
    ready_d    = 1'b0;
    pos_d      = '0;
    if (state_q == S_PLAY) begin
      data_out_d = mem_q[ptr_q[MEM_AW-1:0]];
      ready_d    = 1'b1;
    end
    if ((state_q == S_PLAY) || (state_q == S_PAUSE)) pos_d = ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      div_q      <= TICK_W'(1);
      step_q     <= TICK_W'(1);
      ptr_q      <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      div_q      <= div_d;
      step_q     <= step_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      pos_q      <= pos_d;
    end
  end

  // Note storage has no reset; only slots below count are ever read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[count_q[MEM_AW-1:0]] <= data_in;
  end

  assign prod_w = PW'(count_q) * PW'(div_q);
  assign quot_w = prod_w / PW'(BASE_INTERVAL);

  assign duration     = ((quot_w >> DUR_W) != '0) ? '1 : DUR_W'(quot_w);
  assign data_out     = data_out_q;
  assign output_ready = ready_q;
  assign play_pos     = pos_q;
  assign count        = count_q;
  assign full         = full_w;
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_music_seq_memory.sv
// Directed bench: vector table for write/playback flows, hand sequences for pause,
// saturation, async reset and a full-size instance for the duration scaling.
module tb_music_seq_memory;

  logic       clk;
  logic       rst_n;
  logic       we, clr, st, sp, ps, lp;
  logic [9:0] din;
  logic [7:0] div;
  logic [9:0] dout;
  logic       rdy, full, done;
  logic [3:0] pos, cnt;
  logic [7:0] dur;

  logic        b_we, b_clr, b_st, b_sp, b_ps, b_lp;
  logic [9:0]  b_din;
  logic [26:0] b_div;
  logic [9:0]  b_dout;
  logic        b_rdy, b_full, b_done;
  logic [8:0]  b_pos, b_cnt;
  logic [15:0] b_dur;

  int n_checks = 0;
  int n_err    = 0;

  music_seq_memory #(
    .DATA_WIDTH(10), .DEPTH(8), .ADDR_W(4), .TICK_W(8), .BASE_INTERVAL(1), .DUR_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .write_en(we), .data_in(din), .clear(clr),
    .start(st), .stop(sp), .pause(ps), .loop_en(lp), .tick_div(div),
    .data_out(dout), .output_ready(rdy), .play_pos(pos), .count(cnt),
    .full(full), .done(done), .duration(dur)
  );

  music_seq_memory u_big (
    .clk(clk), .rst_n(rst_n), .write_en(b_we), .data_in(b_din), .clear(b_clr),
    .start(b_st), .stop(b_sp), .pause(b_ps), .loop_en(b_lp), .tick_div(b_div),
    .data_out(b_dout), .output_ready(b_rdy), .play_pos(b_pos), .count(b_cnt),
    .full(b_full), .done(b_done), .duration(b_dur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [9:0] din;
    logic       clr, st, sp, lp;
    logic [7:0] div;
    logic [3:0] cnt;
    logic       full, rdy;
    logic [9:0] dout;
    logic [3:0] pos;
    logic       done;
    logic [7:0] dur;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic a_we, input logic [9:0] a_din, input logic a_clr,
                     input logic a_st, input logic a_sp, input logic a_lp,
                     input logic [7:0] a_div, input logic [3:0] e_cnt,
                     input logic e_full, input logic e_rdy, input logic [9:0] e_dout,
                     input logic [3:0] e_pos, input logic e_done, input logic [7:0] e_dur);
    vec_t v;
    v.we = a_we; v.din = a_din; v.clr = a_clr; v.st = a_st; v.sp = a_sp; v.lp = a_lp;
    v.div = a_div; v.cnt = e_cnt; v.full = e_full; v.rdy = e_rdy; v.dout = e_dout;
    v.pos = e_pos; v.done = e_done; v.dur = e_dur;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  logic [9:0] notes [3];
  logic [9:0] pexp  [19];

  initial begin
    notes[0] = 10'h004; notes[1] = 10'h010; notes[2] = 10'h040;

    rst_n = 1'b0;
    we = 0; din = '0; clr = 0; st = 0; sp = 0; ps = 0; lp = 0; div = '0;
    b_we = 0; b_din = '0; b_clr = 0; b_st = 0; b_sp = 0; b_ps = 0; b_lp = 0; b_div = '0;

    // fill to capacity, overflow write, replay contents, clear beats write
    for (int i = 0; i < 8; i++)
      add(1, 10'(i + 1), 0, 0, 0, 0, 0, 4'(i + 1), (i == 7), 0, 0, 0, 0, 8'(i + 1));
    add(1, 10'h3FF, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 8);
    add(0, 0, 0, 1, 0, 0, 1, 8, 1, 0, 0, 0, 0, 8);
    for (int k = 0; k < 8; k++)
      add(0, 0, 0, 0, 0, 0, 0, 8, 1, 1, 10'(k + 1), 4'(k), (k == 7), 8);
    add(0, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 8);
    add(1, 10'h155, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // three notes, three cycles per step, single pass
    for (int i = 0; i < 3; i++)
      add(1, notes[i], 0, 0, 0, 0, 0, 4'(i + 1), 0, 0, 0, 0, 0, 8'(i + 1));
    add(0, 0, 0, 1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 9);
    for (int j = 0; j < 9; j++)
      add(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, notes[j / 3], 4'(j / 3), (j == 8), 9);
    add(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 9);
    // looping, then stop in the middle of the wrapped first step
    add(0, 0, 0, 1, 0, 1, 3, 3, 0, 0, 0, 0, 0, 9);
    for (int j = 0; j < 10; j++)
      add(0, 0, 0, 0, 0, 1, 0, 3, 0, 1, notes[(j / 3) % 3], 4'((j / 3) % 3), 0, 9);
    add(0, 0, 0, 0, 1, 1, 0, 3, 0, 1, notes[0], 0, 0, 9);
    add(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 9);
    // zero divider runs one cycle per step; writes during playback ignored
    add(0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3);
    add(1, 10'h2AA, 0, 0, 0, 0, 0, 3, 0, 1, notes[0], 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, notes[1], 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, notes[2], 2, 1, 3);
    add(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3);
    // empty memory: start is ignored
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", dout, 0);
    check("rst_ready", rdy, 0);
    check("rst_play_pos", pos, 0);
    check("rst_count", cnt, 0);
    check("rst_full", full, 0);
    check("rst_done", done, 0);
    check("rst_duration", dur, 0);
    check("rst_big_count", b_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < tbl.size(); r++) begin
      we = tbl[r].we; din = tbl[r].din; clr = tbl[r].clr; st = tbl[r].st;
      sp = tbl[r].sp; lp = tbl[r].lp; div = tbl[r].div;
      tick();
      check($sformatf("v%0d_count", r), cnt, tbl[r].cnt);
      check($sformatf("v%0d_full", r), full, tbl[r].full);
      check($sformatf("v%0d_ready", r), rdy, tbl[r].rdy);
      check($sformatf("v%0d_data", r), dout, tbl[r].dout);
      check($sformatf("v%0d_pos", r), pos, tbl[r].pos);
      check($sformatf("v%0d_done", r), done, tbl[r].done);
      check($sformatf("v%0d_dur", r), dur, tbl[r].dur);
    end
    we = 0; clr = 0; st = 0; sp = 0; lp = 0; div = '0;

    // pause for 5 cycles after 2 cycles of step 1 with a divider of 4
    for (int i = 0; i < 3; i++) begin
      we = 1; din = notes[i];
      tick();
    end
    we = 0;
    for (int k = 1; k <= 18; k++) pexp[k] = '0;
    for (int k = 1; k <= 4; k++)  pexp[k] = notes[0];
    for (int k = 5; k <= 7; k++)  pexp[k] = notes[1];
    pexp[13] = notes[1];
    for (int k = 14; k <= 17; k++) pexp[k] = notes[2];
    div = 4; st = 1;
    tick();
    st = 0;
    for (int k = 1; k <= 18; k++) begin
      ps = (k >= 7) && (k <= 11);
      tick();
      check($sformatf("pause_k%0d_data", k), dout, pexp[k]);
      check($sformatf("pause_k%0d_ready", k), rdy, (pexp[k] != 0));
      if (k == 17) check("pause_done", done, 1);
    end
    ps = 0;

    // duration uses the latched divider and saturates
    div = 50; st = 1;
    tick();
    st = 0;
    check("dur_3x50", dur, 150);
    sp = 1;
    tick();
    sp = 0;
    for (int i = 0; i < 5; i++) begin
      we = 1; din = 10'(i + 9);
      tick();
    end
    we = 0;
    check("count_8", cnt, 8);
    check("full_8", full, 1);
    div = 200; st = 1;
    tick();
    st = 0;
    check("dur_saturate", dur, 8'hFF);
    sp = 1;
    tick();
    sp = 0;

    // asynchronous reset mid-playback
    div = 2; st = 1;
    tick();
    st = 0;
    tick();
    tick();
    check("pre_reset_ready", rdy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ready", rdy, 0);
    check("arst_data", dout, 0);
    check("arst_count", cnt, 0);
    check("arst_full", full, 0);
    check("arst_pos", pos, 0);
    check("arst_done", done, 0);
    check("arst_dur", dur, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_ready", rdy, 0);

    // full-size instance: 192 notes at one base interval per step
    for (int i = 0; i < 192; i++) begin
      b_we = 1; b_din = 10'(i + 1);
      tick();
    end
    b_we = 0;
    check("big_count", b_cnt, 192);
    check("big_dur_div1", b_dur, 0);
    b_div = 27'd12500000; b_st = 1;
    tick();
    b_st = 0;
    check("big_dur_192", b_dur, 192);
    tick();
    check("big_ready", b_rdy, 1);
    check("big_data0", b_dout, 1);
    b_sp = 1;
    tick();
    b_sp = 0;
    tick();
    check("big_stop_ready", b_rdy, 0);
    check("big_dur_kept", b_dur, 192);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
